// File: rtl/dport_pkg.sv
// Shared definitions for the display-port pattern generator: mode codes,
// colour-bar table and the frame state enumeration.
package dport_pkg;

  localparam logic [2:0] MODE_SOLID = 3'd0;
  localparam logic [2:0] MODE_BARS  = 3'd1;
  localparam logic [2:0] MODE_RAMP  = 3'd2;
  localparam logic [2:0] MODE_CHECK = 3'd3;
  localparam logic [2:0] MODE_VBAR  = 3'd4;

  // Bar colours as {B,G,R} on/off flags; index 0 is white, 7 is black.
  localparam logic [7:0][2:0] BAR_TABLE = {
    3'b000,  // black
    3'b100,  // blue
    3'b001,  // red
    3'b101,  // magenta
    3'b010,  // green
    3'b110,  // cyan
    3'b011,  // yellow
    3'b111   // white
  };

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACTIVE,
    ST_DONE
  } state_t;

endpackage

// File: rtl/patgen_pix.sv
// Combinational pixel function: one {B,G,R} pixel from pattern mode,
// column, row band, frame count and solid colour.
module patgen_pix
  import dport_pkg::*;
#(
  parameter int BPC   = 8,
  parameter int BARSH = 6
) (
  input  logic [2:0]       mode,
  input  logic [15:0]      px,
  input  logic             yband,
  input  logic [7:0]       frame,
  input  logic [3*BPC-1:0] color,
  output logic [3*BPC-1:0] pixel
);

  logic [2:0]  bar;
  logic [15:0] off;

  assign bar = BAR_TABLE[px[BARSH+2:BARSH]];
  // Column offset from the moving bar's left edge, modulo 2^16.
  assign off = px - {6'b0, frame, 2'b00};

  always_comb begin
    pixel = '0;
    case (mode)
      MODE_BARS: begin
        for (int unsigned c = 0; c < 3; c++) pixel[c*BPC +: BPC] = {BPC{bar[c]}};
      end
      MODE_RAMP:  pixel = {3{px[BPC-1:0]}};
      MODE_CHECK: pixel = {3*BPC{px[BARSH] ^ yband ^ frame[0]}};
      MODE_VBAR:  pixel = {3*BPC{off < 16'(1 << BARSH)}};
      default:    pixel = color;
    endcase
  end

endmodule

// File: rtl/patgen.sv
// Test-pattern generator presenting packed pixel words through a
// first-word-fall-through FIFO-style read interface.
module patgen
  import dport_pkg::*;
#(
  parameter int PIX   = 2,
  parameter int BPC   = 8,
  parameter int BARSH = 6
) (
  input  logic               dpclk,
  input  logic               reset,
  input  logic               vstart,
  input  logic               enable,
  input  logic [2:0]         mode,
  input  logic [15:0]        hact,
  input  logic [15:0]        vact,
  input  logic [3*BPC-1:0]   color,
  input  logic               fiforden,
  output logic [PIX*3*BPC-1:0] fifodo,
  output logic               fifoempty,
  output logic [7:0]         frame
);

  localparam int PW = 3 * BPC;
  localparam int W  = PIX * PW;

  state_t          state;
  logic [15:0]     x, y, hact_q, vact_q;
  logic [2:0]      mode_q;
  logic [PW-1:0]   color_q;

  logic            start, consume, wrap, last;
  logic [15:0]     nx, ny, hact_n;
  logic [2:0]      mode_n;
  logic [PW-1:0]   color_n;
  logic [W-1:0]    word_n;

  assign fifoempty = (state != ST_ACTIVE) || !enable;
  assign start     = vstart && enable;
  assign consume   = fiforden && !fifoempty && !start;
  assign wrap      = ({1'b0, x} + 17'(PIX)) >= {1'b0, hact_q};
  assign last      = wrap && (({1'b0, y} + 17'd1) >= {1'b0, vact_q});

  // Position and config of the word to be loaded next: a restart uses the
  // live inputs so the first word is ready the cycle after vstart.
  always_comb begin
    nx      = '0;
    ny      = '0;
    mode_n  = mode_q;
    hact_n  = hact_q;
    color_n = color_q;
    if (start) begin
      mode_n  = mode;
      hact_n  = hact;
      color_n = color;
    end else if (wrap) begin
      ny = y + 16'd1;
    end else begin
      nx = x + 16'(PIX);
      ny = y;
    end
  end

  for (genvar k = 0; k < PIX; k++) begin : g_pix
    logic [PW-1:0] pixel;
    logic          in_line;

    assign in_line = ({1'b0, nx} + 17'(k)) < {1'b0, hact_n};

    patgen_pix #(
      .BPC  (BPC),
      .BARSH(BARSH)
    ) u_pix (
      .mode (mode_n),
      .px   (nx + 16'(k)),
      .yband(ny[BARSH]),
      .frame(frame),
      .color(color_n),
      .pixel(pixel)
    );

    assign word_n[k*PW +: PW] = in_line ? pixel : '0;
  end

  always_ff @(posedge dpclk or posedge reset) begin
    if (reset) begin
      state   <= ST_IDLE;
      x       <= '0;
      y       <= '0;
      hact_q  <= '0;
      vact_q  <= '0;
      mode_q  <= '0;
      color_q <= '0;
      frame   <= '0;
      fifodo  <= '0;
    end else if (start) begin
      state   <= (hact == '0 || vact == '0) ? ST_DONE : ST_ACTIVE;
      x       <= '0;
      y       <= '0;
      hact_q  <= hact;
      vact_q  <= vact;
      mode_q  <= mode;
      color_q <= color;
      fifodo  <= word_n;
    end else if (consume) begin
      if (last) begin
        state <= ST_DONE;
        frame <= frame + 8'd1;
        x     <= '0;
        y     <= '0;
      end else begin
        x      <= nx;
        y      <= ny;
        fifodo <= word_n;
      end
    end
  end

endmodule

// File: tb/tb_patgen.sv
// Randomized bench for patgen at default parameters against a behavioural
// frame/pixel model.
module tb_patgen;

  logic        dpclk = 1'b0;
  logic        reset, vstart, enable, fiforden;
  logic [2:0]  mode;
  logic [15:0] hact, vact;
  logic [23:0] color;
  logic [47:0] fifodo;
  logic        fifoempty;
  logic [7:0]  frame;

  int n_assert = 0;
  int n_fail   = 0;

  int          mx, my, mhact, mvact, mmode, mframe;
  logic [23:0] mcolor;
  bit          mact;
  int          saved_frame;

  always #5 dpclk = ~dpclk;

  patgen #(.PIX(2), .BPC(8), .BARSH(6)) dut (
    .dpclk    (dpclk),
    .reset    (reset),
    .vstart   (vstart),
    .enable   (enable),
    .mode     (mode),
    .hact     (hact),
    .vact     (vact),
    .color    (color),
    .fiforden (fiforden),
    .fifodo   (fifodo),
    .fifoempty(fifoempty),
    .frame    (frame)
  );

  function automatic logic [23:0] mpix(input int md, input int p, input int yy,
                                       input int f, input logic [23:0] col);
    logic [23:0] bars [8];
    logic [7:0]  v8;
    bars = '{24'hFFFFFF, 24'h00FFFF, 24'hFFFF00, 24'h00FF00,
             24'hFF00FF, 24'h0000FF, 24'hFF0000, 24'h000000};
    case (md)
      1: return bars[(p / 64) % 8];
      2: begin v8 = 8'(p % 256); return {v8, v8, v8}; end
      3: return ((((p / 64) + (yy / 64) + f) % 2) == 1) ? 24'hFFFFFF : 24'h0;
      4: return (((p + 65536 - f * 4) % 65536) < 64) ? 24'hFFFFFF : 24'h0;
      default: return col;
    endcase
  endfunction

  function automatic logic [47:0] mword();
    logic [47:0] w;
    w = '0;
    for (int k = 0; k < 2; k++)
      if (mx + k < mhact) w[k*24 +: 24] = mpix(mmode, (mx + k) % 65536, my, mframe, mcolor);
    return w;
  endfunction

  task automatic chk(input string tag, input logic [47:0] obs, input logic [47:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One clock: set enable, check outputs, apply strobes, advance the model.
  task automatic tick(input bit vs, input bit rd, input bit en);
    bit exp_empty;
    enable = en;
    #1;
    exp_empty = !(mact && en);
    chk("fifoempty", {47'b0, fifoempty}, {47'b0, exp_empty});
    if (!exp_empty) chk("fifodo", fifodo, mword());
    chk("frame", {40'b0, frame}, {40'b0, 8'(mframe)});
    vstart   = vs;
    fiforden = rd;
    @(posedge dpclk);
    if (vs && en) begin
      mx = 0; my = 0;
      mhact = int'(hact); mvact = int'(vact); mmode = int'(mode); mcolor = color;
      mact = (hact != 0) && (vact != 0);
    end else if (rd && !exp_empty) begin
      if (mx + 2 >= mhact) begin
        mx = 0;
        my++;
        if (my >= mvact) begin
          mact   = 0;
          mframe = (mframe + 1) % 256;
        end
      end else begin
        mx += 2;
      end
    end
    @(negedge dpclk);
    vstart   = 1'b0;
    fiforden = 1'b0;
  endtask

  task automatic set_cfg(input int md, input int ha, input int va, input logic [23:0] col);
    mode  = 3'(md);
    hact  = 16'(ha);
    vact  = 16'(va);
    color = col;
  endtask

  task automatic finish_frame(input int rdpct, input int enpct, input int budget);
    int n;
    n = 0;
    while (mact && n < budget) begin
      tick(1'b0, ($urandom % 100) < rdpct, ($urandom % 100) < enpct);
      n++;
    end
    n_assert++;
    assert (!mact) else begin
      n_fail++;
      $error("FAIL budget: frame still active after %0d cycles", n);
    end
    tick(1'b0, 1'b1, 1'b1);
  endtask

  task automatic run_frame(input int md, input int ha, input int va, input logic [23:0] col,
                           input int rdpct, input int enpct, input int budget);
    set_cfg(md, ha, va, col);
    tick(1'b1, ($urandom % 2) == 1, 1'b1);
    finish_frame(rdpct, enpct, budget);
  endtask

  initial begin
    reset = 1'b1; vstart = 1'b0; enable = 1'b0; fiforden = 1'b0;
    set_cfg(0, 0, 0, 24'h0);
    mx = 0; my = 0; mhact = 0; mvact = 0; mmode = 0; mframe = 0; mcolor = '0; mact = 0;
    @(negedge dpclk); @(negedge dpclk);
    chk("rst_empty", {47'b0, fifoempty}, 48'd1);
    chk("rst_fifodo", fifodo, 48'd0);
    chk("rst_frame", {40'b0, frame}, 48'd0);
    reset = 1'b0;
    @(negedge dpclk);

    // Solid colour, continuous reads.
    set_cfg(0, 64, 4, 24'hFFCCAA);
    tick(1'b1, 1'b0, 1'b1);
    chk("solid_w0", fifodo, 48'hFFCCAAFFCCAA);
    finish_frame(100, 100, 400);
    chk("solid_frame", {40'b0, frame}, 48'd1);

    // Colour bars: spot values at x=64 and x=448.
    set_cfg(1, 640, 1, 24'h0);
    tick(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 32; i++) tick(1'b0, 1'b1, 1'b1);
    chk("bar_x64", fifodo, 48'h00FFFF00FFFF);
    for (int i = 0; i < 192; i++) tick(1'b0, 1'b1, 1'b1);
    chk("bar_x448", fifodo, 48'h0);
    finish_frame(100, 100, 400);

    // Odd line width: final word of each line has a zeroed upper pixel.
    run_frame(2, 5, 3, 24'h0, 60, 100, 200);

    // Mid-frame restart; vstart coincident with a read wins.
    set_cfg(2, 640, 4, 24'h0);
    tick(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 100; i++) tick(1'b0, 1'b1, 1'b1);
    saved_frame = mframe;
    tick(1'b1, 1'b1, 1'b1);
    chk("restart_w0", fifodo, 48'h010101000000);
    chk("restart_frame", {40'b0, frame}, {40'b0, 8'(saved_frame)});
    finish_frame(100, 100, 2000);

    // Checkerboard across two row bands, sparse reads.
    run_frame(3, 200, 70, 24'h0, 80, 100, 20000);

    // Moving vertical bar over several frames.
    for (int f = 0; f < 3; f++) run_frame(4, 128, 2, 24'h0, 90, 100, 600);

    // Enable toggling with random reads.
    run_frame(5, 33, 3, 24'($urandom), 70, 70, 2000);
    run_frame(1, 130, 3, 24'h0, 50, 60, 3000);

    // Degenerate sizes complete with no words.
    run_frame(0, 0, 5, 24'h123456, 100, 100, 10);
    run_frame(0, 7, 0, 24'h123456, 100, 100, 10);

    // Asynchronous reset mid-frame.
    set_cfg(1, 64, 4, 24'h0);
    tick(1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 20; i++) tick(1'b0, 1'b1, 1'b1);
    #2 reset = 1'b1;
    #1;
    chk("arst_empty", {47'b0, fifoempty}, 48'd1);
    chk("arst_frame", {40'b0, frame}, 48'd0);
    chk("arst_fifodo", fifodo, 48'd0);
    mact = 0; mframe = 0;
    @(negedge dpclk);
    reset = 1'b0;
    @(negedge dpclk);
    run_frame(2, 16, 2, 24'h0, 100, 100, 100);
    chk("post_rst_frame", {40'b0, frame}, 48'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/patgen.md
PATGEN -- requirements
Module: patgen

Interface
REQ-001 Parameter PIX, default 2: pixels packed per output word; legal values 1, 2, 4.
REQ-002 Parameter BPC, default 8: bits per colour component; legal values 6, 8, 10.
REQ-003 Parameter BARSH, default 6: log2 of colour-bar and checker-square width in pixels.
REQ-004 Derived width W = PIX*3*BPC: 48 at defaults.
REQ-005 The block SHALL have exactly one clock, dpclk, input, 1 bit, sampled on its rising edge.
REQ-006 reset  input  1  asynchronous, active-high; clears all state.
REQ-007 vstart  input  1  frame-start pulse, one cycle, from the pixel timing generator.
REQ-008 enable  input  1  0 forces fifoempty high and freezes position.
REQ-009 mode  input  3  pattern select; sampled at vstart.
REQ-010 hact  input  16  active pixels per line; sampled at vstart.
REQ-011 vact  input  16  active lines per frame; sampled at vstart.
REQ-012 color  input  3*BPC  solid colour {B,G,R}; sampled at vstart.
REQ-013 fiforden  input  1  consumer read strobe.
REQ-014 fifodo  output  W  pixel word; pixel k occupies bits [k*3*BPC +: 3*BPC]; within a pixel, R is low, G middle, B high.
REQ-015 fifoempty  output  1  1 means no valid word on fifodo.
REQ-016 frame  output  8  count of completed frames, wrapping.

Function
REQ-017 fifodo is first-word-fall-through: it SHALL be valid whenever fifoempty=0.
REQ-018 fiforden with fifoempty=0 consumes the word; the next word SHALL be valid on the following cycle, allowing one word per cycle.
REQ-019 fiforden with fifoempty=1 SHALL be ignored.
REQ-020 A word not consumed SHALL be held stable.
REQ-021 States are IDLE, ACTIVE and DONE.
REQ-022 IDLE -> ACTIVE on vstart with enable=1, with x=0, y=0 and fifoempty=0 on the next cycle.
REQ-023 ACTIVE -> DONE on consumption of the last word of line vact-1; at that point fifoempty=1 and frame increments.
REQ-024 DONE -> ACTIVE on vstart.
REQ-025 vstart in ACTIVE SHALL restart at x=0, y=0 and discard the pending word; frame does not increment.
REQ-026 vstart coincident with fiforden: vstart SHALL win.
REQ-027 Each consumption advances x by PIX.
REQ-028 When x+PIX >= hact, x -> 0 and y -> y+1.
REQ-029 When hact is not a multiple of PIX, pixel positions >= hact in the final word SHALL be all zeros.
REQ-030 x and y are 16 bits wide.
REQ-031 hact=0 or vact=0 SHALL go straight to DONE with no words output.
REQ-032 Pixel value is a function of (mode, x+k, y, frame). Define MAX = all-ones BPC.
REQ-033 mode 0: the latched color.
REQ-034 mode 1: eight bars indexed by (x+k)[BARSH+2:BARSH] — white, yellow, cyan, green, magenta, red, blue, black; components are MAX or 0.
REQ-035 mode 2: R=G=B=(x+k)[BPC-1:0] (horizontal ramp).
REQ-036 mode 3: checkerboard; MAX grey when (x+k)[BARSH]^y[BARSH]^frame[0], else 0.
REQ-037 mode 4: white vertical bar 2^BARSH wide at column frame<<2 (mod 2^16), black elsewhere.
REQ-038 modes 5-7: same as mode 0.
REQ-039 enable=0 SHALL force fifoempty=1 without losing position; deasserting enable mid-frame resumes on the same word.

Reset
REQ-040 On reset: state=IDLE, fifoempty=1, fifodo=0, frame=0, x=0, y=0, latched config=0.
REQ-041 Reset SHALL take effect asynchronously.
REQ-042 Release SHALL be synchronous to dpclk.
REQ-043 The first vstart after release starts frame 0.

Structure
REQ-044 Shared package dport_pkg holds: the mode encoding constants, the bar colour table and the state enumeration.
REQ-045 One sub-module, patgen_pix: combinational pixel function of (mode, x, y, frame, color), instantiated PIX times.
REQ-046 patgen_pix feeds a single registered output stage.

Verification
REQ-047 Defaults, mode 0, color=24'hFFCCAA, hact=640, vact=480, fiforden=1 -> 153600 words of 48'hFFCCAAFFCCAA, then fifoempty=1, frame=1.
REQ-048 mode 1, hact=640 -> word at x=64 is {yellow,yellow}=48'h00FFFF00FFFF; word at x=448 is 0.
REQ-049 PIX=4, hact=6, vact=2, mode 2 -> words per line carry pixels 0-3, then 4,5,0,0; 4 words total.
REQ-050 fiforden toggling 1,0,1 -> fifodo held during the 0 cycle; no word skipped or repeated.
REQ-051 vstart at word 100 of a frame -> next word is x=0, y=0 and frame is unchanged.
REQ-052 Reset asserted mid-frame -> fifoempty=1 and frame=0 immediately, without a clock edge.
